// File: rtl/mc_datapath_regs_pkg.sv
// Shared constants for the multicycle RV32I datapath.
// Opcodes match the control FSM decode.
package mc_datapath_regs_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 32;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] HALT_CODE = 32'd10;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

endpackage

// File: rtl/mc_datapath_regs_if.sv
// Control strobes and data buses between the FSM/ALU/memory side
// and the datapath register file.
interface mc_datapath_regs_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic            pc_write;
  logic            pc_write_not_cond;
  logic            pc_source;
  logic            ir_write;
  logic            i_or_d;
  logic            alu_bcond;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] mem_dout;
  logic [XLEN-1:0] rs1_dout;
  logic [XLEN-1:0] rs2_dout;
  logic [XLEN-1:0] x17_value;
  logic            is_ecall;

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  ir;
  logic [6:0]       part_of_inst;
  logic [XLEN-1:0]  mdr;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  alu_out_q;
  logic             is_halted;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output pc_write, pc_write_not_cond, pc_source,
    output ir_write, i_or_d, alu_bcond,
    output alu_result, mem_dout, rs1_dout, rs2_dout,
    output x17_value, is_ecall,
    input  pc, mem_addr, ir, part_of_inst, mdr,
    input  a_q, b_q, alu_out_q, is_halted, retired_cnt
  );

  modport slave (
    input  pc_write, pc_write_not_cond, pc_source,
    input  ir_write, i_or_d, alu_bcond,
    input  alu_result, mem_dout, rs1_dout, rs2_dout,
    input  x17_value, is_ecall,
    output pc, mem_addr, ir, part_of_inst, mdr,
    output a_q, b_q, alu_out_q, is_halted, retired_cnt
  );
endinterface

// File: rtl/mc_datapath_regs_en_reg.sv
// Width-parameterised register with synchronous reset and load enable.
module en_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= RST_VAL;
    else       q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/mc_datapath_regs.sv
// PC/IR/MDR/A/B/ALUOut registers, halt flag and retired counter
// for the multicycle RV32I datapath.
module mc_datapath_regs
  import mc_datapath_regs_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = mc_datapath_regs_pkg::RESET_PC,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  mc_datapath_regs_if.slave bus
);
  logic [XLEN-1:0]  pc_w;
  logic [XLEN-1:0]  ir_w;
  logic [XLEN-1:0]  mdr_w;
  logic [XLEN-1:0]  a_w;
  logic [XLEN-1:0]  b_w;
  logic [XLEN-1:0]  alu_out_w;
  logic [XLEN-1:0]  next_pc;
  logic             pc_we;
  logic             pc_en;
  logic             ir_en;
  logic             halt_hit;

  logic             halted_d;
  logic             halted_q;
  logic             ir_valid_d;
  logic             ir_valid_q;
  logic [CNT_W-1:0] retired_d;
  logic [CNT_W-1:0] retired_q;

  always_comb begin
    pc_we    = bus.pc_write |
               (bus.pc_write_not_cond & ~bus.alu_bcond);
    next_pc  = bus.pc_source ? alu_out_w : bus.alu_result;
    // Freeze uses the registered flag so a halting edge still writes PC.
    pc_en    = pc_we & ~halted_q;
    ir_en    = bus.ir_write & ~halted_q;
    halt_hit = ir_valid_q & bus.is_ecall &
               (bus.x17_value == XLEN'(HALT_CODE));
  end

  always_comb begin
    halted_d   = halted_q | halt_hit;
    ir_valid_d = ir_valid_q;
    retired_d  = retired_q;
    if (ir_en) begin
      ir_valid_d = 1'b1;
      retired_d  = retired_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halted_q   <= 1'b0;
      ir_valid_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      halted_q   <= halted_d;
      ir_valid_q <= ir_valid_d;
      retired_q  <= retired_d;
    end
  end

  en_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .en(pc_en),
    .d(next_pc), .q(pc_w)
  );

  en_reg #(.W(XLEN)) u_ir (
    .clk(clk), .reset(reset), .en(ir_en),
    .d(bus.mem_dout), .q(ir_w)
  );

  en_reg #(.W(XLEN)) u_mdr (
    .clk(clk), .reset(reset), .en(1'b1),
    .d(bus.mem_dout), .q(mdr_w)
  );

  en_reg #(.W(XLEN)) u_a (
    .clk(clk), .reset(reset), .en(1'b1),
    .d(bus.rs1_dout), .q(a_w)
  );

  en_reg #(.W(XLEN)) u_b (
    .clk(clk), .reset(reset), .en(1'b1),
    .d(bus.rs2_dout), .q(b_w)
  );

  en_reg #(.W(XLEN)) u_alu_out (
    .clk(clk), .reset(reset), .en(1'b1),
    .d(bus.alu_result), .q(alu_out_w)
  );

  assign bus.pc           = pc_w;
  assign bus.ir           = ir_w;
  assign bus.part_of_inst = ir_w[6:0];
  assign bus.mdr          = mdr_w;
  assign bus.a_q          = a_w;
  assign bus.b_q          = b_w;
  assign bus.alu_out_q    = alu_out_w;
  assign bus.mem_addr     = bus.i_or_d ? alu_out_w : pc_w;
  assign bus.is_halted    = halted_q;
  assign bus.retired_cnt  = retired_q;
endmodule

// File: tb/tb_mc_datapath_regs.sv
// Directed vector bench for mc_datapath_regs.
module tb_mc_datapath_regs;
  logic clk;
  logic rst;
  logic rst2;
  int   n_pass;
  int   n_tot;

  mc_datapath_regs_if #(.XLEN(32), .CNT_W(32)) bus ();
  mc_datapath_regs_if #(.XLEN(32), .CNT_W(3))  bus2 ();

  mc_datapath_regs #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );

  mc_datapath_regs #(.XLEN(32), .CNT_W(3)) dut2 (
    .clk(clk), .reset(rst2), .bus(bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        pw;
    logic        pwnc;
    logic        src;
    logic        irw;
    logic        iord;
    logic        bc;
    logic        ec;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] x17;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic [31:0] e_ret;
    logic        e_halt;
    logic [31:0] e_aluq;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst                   = v.rst;
    bus.pc_write          = v.pw;
    bus.pc_write_not_cond = v.pwnc;
    bus.pc_source         = v.src;
    bus.ir_write          = v.irw;
    bus.i_or_d            = v.iord;
    bus.alu_bcond         = v.bc;
    bus.is_ecall          = v.ec;
    bus.alu_result        = v.alu;
    bus.mem_dout          = v.mem;
    bus.x17_value         = v.x17;
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst2   = 1'b1;
    bus.rs1_dout = '0;
    bus.rs2_dout = '0;
    bus2.pc_write = 0; bus2.pc_write_not_cond = 0;
    bus2.pc_source = 0; bus2.ir_write = 0; bus2.i_or_d = 0;
    bus2.alu_bcond = 0; bus2.is_ecall = 0;
    bus2.alu_result = '0; bus2.mem_dout = '0;
    bus2.rs1_dout = '0; bus2.rs2_dout = '0;
    bus2.x17_value = '0;

    //        rst pw nc sr ir id bc ec alu     mem    x17  pc     ir    ret h aluq    addr
    vecs[0]  = '{1,0,0,0,0,0,0,0,32'h0,  32'h0, 0, 32'h0, 32'h0, 0,0,32'h0,  32'h0};
    vecs[1]  = '{0,0,0,0,1,0,0,0,32'h0,  32'h33,0, 32'h0, 32'h33,1,0,32'h0,  32'h0};
    vecs[2]  = '{0,0,0,0,0,0,0,0,32'h4,  32'h0, 0, 32'h0, 32'h33,1,0,32'h4,  32'h0};
    vecs[3]  = '{0,1,0,0,0,0,0,0,32'h4,  32'h0, 0, 32'h4, 32'h33,1,0,32'h4,  32'h4};
    vecs[4]  = '{0,0,0,0,0,0,0,0,32'h8,  32'h0, 0, 32'h4, 32'h33,1,0,32'h8,  32'h4};
    vecs[5]  = '{0,0,1,1,0,0,0,0,32'hc,  32'h0, 0, 32'h8, 32'h33,1,0,32'hc,  32'h8};
    vecs[6]  = '{0,0,1,1,0,0,1,0,32'hc,  32'h0, 0, 32'h8, 32'h33,1,0,32'hc,  32'h8};
    vecs[7]  = '{0,1,1,0,0,0,1,0,32'h14, 32'h0, 0, 32'h14,32'h33,1,0,32'h14, 32'h14};
    vecs[8]  = '{0,0,0,0,0,1,0,0,32'h100,32'h0, 0, 32'h14,32'h33,1,0,32'h100,32'h100};
    vecs[9]  = '{0,0,0,0,0,0,0,0,32'h0,  32'h0, 0, 32'h14,32'h33,1,0,32'h0,  32'h14};
    vecs[10] = '{0,0,0,0,0,0,0,1,32'h0,  32'h0, 9, 32'h14,32'h33,1,0,32'h0,  32'h14};
    vecs[11] = '{0,1,0,0,0,0,0,1,32'h40, 32'h0, 10,32'h40,32'h33,1,1,32'h40, 32'h40};
    vecs[12] = '{0,1,0,0,1,0,0,0,32'h80, 32'h13,0, 32'h40,32'h33,1,1,32'h80, 32'h40};
    vecs[13] = '{0,0,1,1,0,0,0,0,32'h0,  32'h0, 0, 32'h40,32'h33,1,1,32'h0,  32'h40};
    vecs[14] = '{1,1,0,0,1,0,0,0,32'h55, 32'h73,0, 32'h0, 32'h0, 0,0,32'h0,  32'h0};
    vecs[15] = '{0,0,0,0,0,0,0,1,32'h0,  32'h0, 10,32'h0, 32'h0, 0,0,32'h0,  32'h0};
    vecs[16] = '{0,0,0,0,1,0,0,1,32'h0,  32'h73,10,32'h0, 32'h73,1,0,32'h0,  32'h0};
    vecs[17] = '{0,0,0,0,0,0,0,1,32'h0,  32'h0, 10,32'h0, 32'h73,1,1,32'h0,  32'h0};

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pc", i), 64'(bus.pc), 64'(vecs[i].e_pc));
      check($sformatf("v%0d_ir", i), 64'(bus.ir), 64'(vecs[i].e_ir));
      check($sformatf("v%0d_poi", i), 64'(bus.part_of_inst),
            64'(vecs[i].e_ir[6:0]));
      check($sformatf("v%0d_ret", i), 64'(bus.retired_cnt),
            64'(vecs[i].e_ret));
      check($sformatf("v%0d_halt", i), 64'(bus.is_halted),
            64'(vecs[i].e_halt));
      check($sformatf("v%0d_aluq", i), 64'(bus.alu_out_q),
            64'(vecs[i].e_aluq));
      check($sformatf("v%0d_addr", i), 64'(bus.mem_addr),
            64'(vecs[i].e_addr));
    end

    // Halted: free-running regs still follow inputs with one-cycle lag.
    bus.is_ecall   = 1'b0;
    bus.rs1_dout   = 32'hAAAA_0001;
    bus.rs2_dout   = 32'hBBBB_0002;
    bus.mem_dout   = 32'hCCCC_0003;
    bus.alu_result = 32'hDDDD_0004;
    bus.ir_write   = 1'b1;
    bus.pc_write   = 1'b1;
    #1;
    check("lag_a_pre", 64'(bus.a_q), 64'h0);
    check("lag_mdr_pre", 64'(bus.mdr), 64'h0);
    @(posedge clk);
    #1;
    check("halt_a_q", 64'(bus.a_q), 64'hAAAA_0001);
    check("halt_b_q", 64'(bus.b_q), 64'hBBBB_0002);
    check("halt_mdr", 64'(bus.mdr), 64'hCCCC_0003);
    check("halt_aluq", 64'(bus.alu_out_q), 64'hDDDD_0004);
    check("halt_pc_frz", 64'(bus.pc), 64'h0);
    check("halt_ir_frz", 64'(bus.ir), 64'h73);
    check("halt_ret_frz", 64'(bus.retired_cnt), 64'd1);
    check("halt_sticky", 64'(bus.is_halted), 64'd1);
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;

    // Counter wrap on a 3-bit instance: 8 loads return it to zero.
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus2.ir_write = 1'b1;
      bus2.mem_dout = 32'(i + 1);
      @(posedge clk);
      #1;
      check($sformatf("wrap_%0d", i), 64'(bus2.retired_cnt),
            64'((i + 1) % 8));
    end
    bus2.ir_write = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
